load_cell_seq: RTL
==================

LOAD_CELL_SEQ -- requirements
Module: load_cell_seq

Interface
REQ-001 SHALL provide parameter SETTLE, default 2, meaning idle clk cycles between the command SPI transaction and the read SPI transaction (legal 1..15).
REQ-002 SHALL provide port clk  input  1  50 MHz system clock, all state on rising edge.
REQ-003 SHALL provide port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL provide port nxt  input  1  single-cycle request to convert the next channel in the round-robin order.
REQ-005 SHALL provide port wrt  output  1  single-cycle strobe starting one SPI transaction.
REQ-006 SHALL provide port cmd  output  16  word transmitted by the SPI master on wrt.
REQ-007 SHALL provide port done  input  1  single-cycle strobe from the SPI master when a transaction completes.
REQ-008 SHALL provide port rd_data  input  16  word received in the transaction ending on done.
REQ-009 SHALL provide outputs lft_ld, rght_ld, steer_pot, batt  output  12 each  latest registered conversion per channel.
REQ-010 SHALL provide port busy  output  1  high from accepted nxt until result written.
REQ-011 SHALL provide port rnd_vld  output  1  single-cycle pulse when the batt result (last of a round) is written.

Function
REQ-012 SHALL sequence channels in fixed order lft(ch 0) -> rght(ch 4) -> steer_pot(ch 5) -> batt(ch 6) -> lft, one channel per accepted nxt.
REQ-013 SHALL use states IDLE, CMD, SETTLE, READ, WR_RES.
REQ-014 IDLE: nxt=1 -> assert wrt one cycle with cmd={2'b00, ch[2:0], 11'h000}, go CMD, busy=1 from the next cycle.
REQ-015 CMD: wait for done; on done clear settle counter, go SETTLE; rd_data of this transaction SHALL be discarded.
REQ-016 SETTLE: count SETTLE cycles; on count reaching SETTLE-1 assert wrt with identical cmd, go READ.
REQ-017 READ: on done capture rd_data[11:0] into the register of the current channel, go WR_RES.
REQ-018 WR_RES: advance channel pointer (batt wraps to lft), pulse rnd_vld if channel was batt, deassert busy, go IDLE; occupies exactly one cycle.
REQ-019 Result register SHALL update on the clock edge following the READ-state done; other three registers SHALL hold.
REQ-020 nxt while busy=1 SHALL be ignored (not queued); nxt in the WR_RES cycle SHALL be ignored.
REQ-021 done outside CMD/READ SHALL be ignored; wrt SHALL never assert outside IDLE->CMD and SETTLE->READ transitions.
REQ-022 cmd SHALL be held stable from its wrt cycle until the next wrt.
REQ-023 Minimum latency nxt -> result write = 2 SPI transactions + SETTLE + 2 cycles.

Reset
REQ-024 On rst_n low: state IDLE, channel pointer lft, settle counter 0, wrt 0, cmd 16'h0000, busy 0, rnd_vld 0, all four result registers 12'h000.
REQ-025 Reset asserted mid-transaction SHALL abandon the transaction; a done arriving after reset release SHALL be ignored (state IDLE).

Structure
REQ-026 State enum and channel-number constants (0,4,5,6) SHALL live in shared package seg_pkg.
REQ-027 Single flat module; SPI master is external; no sub-module instantiated.

Verification
REQ-028 Reset, nxt, SPI model returns 16'h0ABC on read -> first wrt cmd=16'h0000, second wrt cmd=16'h0000 after 2 idle cycles, lft_ld=12'hABC, others 12'h000.
REQ-029 Four nxt pulses, model returns 12'h111/222/333/444 -> lft/rght/steer_pot/batt hold those values, cmds 16'h0000/2000/2800/3000, one rnd_vld pulse after batt write.
REQ-030 Fifth nxt -> cmd 16'h0000 (wrap to lft), only lft_ld changes.
REQ-031 nxt held high for 20 cycles during conversion -> exactly one conversion, one wrt pair.
REQ-032 rst_n low while in READ, later spurious done -> outputs reset values, no wrt, busy 0.
REQ-033 SETTLE=5, model rd_data upper bits 4'hF -> 5 idle cycles between done and second wrt; result uses bits [11:0] only.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the load-cell / pot / battery conversion sequencer:
// FSM state encoding, A2D channel numbers and the SPI command word format.
package seg_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_SETTLE,
      S_READ,
      S_WR_RES
   } state_e;

   localparam logic [2:0] CH_LFT   = 3'd0;
   localparam logic [2:0] CH_RGHT  = 3'd4;
   localparam logic [2:0] CH_STEER = 3'd5;
   localparam logic [2:0] CH_BATT  = 3'd6;

   localparam int NUM_CH = 4;

   // Round-robin slot index -> physical A2D channel number.
   function automatic logic [2:0] ch_num(input logic [1:0] idx);
      logic [2:0] ch;
      case (idx)
         2'd0:    ch = CH_LFT;
         2'd1:    ch = CH_RGHT;
         2'd2:    ch = CH_STEER;
         default: ch = CH_BATT;
      endcase
      return ch;
   endfunction

   function automatic logic [15:0] ch_cmd(input logic [2:0] ch);
      return {2'b00, ch, 11'h000};
   endfunction

endpackage

// File: rtl/load_cell_seq.sv
// Round-robin A2D sequencer: each accepted nxt issues a command SPI transaction,
// waits SETTLE idle cycles, repeats the command to read back, and latches the result.
module load_cell_seq
   import seg_pkg::*;
#(
   parameter int SETTLE = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        nxt,
   output logic        wrt,
   output logic [15:0] cmd,
   input  logic        done,
   input  logic [15:0] rd_data,
   output logic [11:0] lft_ld,
   output logic [11:0] rght_ld,
   output logic [11:0] steer_pot,
   output logic [11:0] batt,
   output logic        busy,
   output logic        rnd_vld
);

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

   state_e      state_q, state_d;
   logic [1:0]  ptr_q, ptr_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        wrt_q, wrt_d;
   logic [15:0] cmd_q, cmd_d;
   logic        busy_q, busy_d;
   logic        rnd_q, rnd_d;
   logic        res_capture;
   logic [11:0] res_q [NUM_CH];

   // Only the 12-bit conversion field of the read word is meaningful.
   logic unused_rd_hi;
   assign unused_rd_hi = ^rd_data[15:12];

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      wrt_d       = 1'b0;
      cmd_d       = cmd_q;
      busy_d      = busy_q;
      rnd_d       = 1'b0;
      res_capture = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (nxt) begin
               wrt_d   = 1'b1;
               cmd_d   = ch_cmd(ch_num(ptr_q));
               busy_d  = 1'b1;
               state_d = S_CMD;
            end
         end
         S_CMD: begin
            // The reply to the command transaction carries stale data and is dropped.
            if (done) begin
               cnt_d   = 4'd0;
               state_d = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               wrt_d   = 1'b1;
               state_d = S_READ;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_READ: begin
            if (done) begin
               res_capture = 1'b1;
               rnd_d       = (ptr_q == 2'd3);
               state_d     = S_WR_RES;
            end
         end
         S_WR_RES: begin
            ptr_d   = ptr_q + 2'd1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ptr_q   <= 2'd0;
         cnt_q   <= 4'd0;
         wrt_q   <= 1'b0;
         cmd_q   <= 16'h0000;
         busy_q  <= 1'b0;
         rnd_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         wrt_q   <= wrt_d;
         cmd_q   <= cmd_d;
         busy_q  <= busy_d;
         rnd_q   <= rnd_d;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_res
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               res_q[gi] <= 12'h000;
            end else if (res_capture && (ptr_q == 2'(gi))) begin
               res_q[gi] <= rd_data[11:0];
            end
         end
      end
   endgenerate

   assign wrt       = wrt_q;
   assign cmd       = cmd_q;
   assign busy      = busy_q;
   assign rnd_vld   = rnd_q;
   assign lft_ld    = res_q[0];
   assign rght_ld   = res_q[1];
   assign steer_pot = res_q[2];
   assign batt      = res_q[3];

endmodule
